// File: rtl/adc_scan_scheduler.sv
// Periodic multi-channel scan sequencer for a single MCP3201 reader
// behind an external analog mux; one result register per channel.
module adc_scan_scheduler #(
  parameter int N_CH         = 4,
  parameter int RES          = 12,
  parameter int SETTLE_CYC   = 50,
  parameter int PERIOD_CYC   = 5000,
  parameter int START_TO_CYC = 64
) (
  input  logic                clk_i,
  input  logic                nReset_i,
  input  logic                enable_i,
  input  logic [N_CH-1:0]     ch_mask_i,
  input  logic                adc_finish_i,
  input  logic [RES-1:0]      adc_data_i,
  output logic                adc_enable_o,
  output logic [2:0]          mux_sel_o,
  output logic [N_CH*RES-1:0] ch_data_o,
  output logic [N_CH-1:0]     ch_valid_o,
  output logic                scan_done_o,
  output logic                busy_o,
  output logic                overrun_o,
  output logic                timeout_o
);

  localparam int PW   = $clog2(PERIOD_CYC + 1);
  localparam int WMAX = (SETTLE_CYC > START_TO_CYC) ?
                        SETTLE_CYC : START_TO_CYC;
  localparam int WW   = $clog2(WMAX + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SELECT,
    S_START,
    S_CONVERT,
    S_STORE
  } state_t;

  state_t          r_state;
  state_t          w_nxt;
  logic [PW-1:0]   r_per_cnt;
  logic [WW-1:0]   r_wait;
  logic [2:0]      r_ch;
  logic [N_CH-1:0] r_mask;
  logic            r_abort;
  logic            r_ovr;
  logic            r_to;
  logic [N_CH-1:0] r_valid;
  logic [RES-1:0]  r_data [N_CH];

  logic            w_tick;
  logic [3:0]      w_first;
  logic [3:0]      w_next;
  logic            w_sel_ld;
  logic [2:0]      w_sel_val;
  logic            w_store;
  logic            w_done;
  logic            w_to;

  // {found, index} of the lowest set bit at or above lo
  function automatic logic [3:0] f_next(
    input logic [N_CH-1:0] m,
    input logic [3:0]      lo
  );
    logic [3:0] r;
    r = '0;
    for (int k = N_CH - 1; k >= 0; k--) begin
      if (m[k] && k >= int'(lo)) r = {1'b1, 3'(k)};
    end
    return r;
  endfunction

  assign w_tick  = enable_i &&
                   (r_per_cnt == PW'(PERIOD_CYC - 1));
  assign w_first = f_next(ch_mask_i, 4'd0);
  assign w_next  = f_next(r_mask, {1'b0, r_ch} + 4'd1);

  always_comb begin
    w_nxt     = r_state;
    w_sel_ld  = 1'b0;
    w_sel_val = r_ch;
    w_store   = 1'b0;
    w_done    = 1'b0;
    w_to      = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_tick && ch_mask_i != '0) begin
          w_nxt     = S_SELECT;
          w_sel_ld  = 1'b1;
          w_sel_val = w_first[2:0];
        end
      end
      S_SELECT: begin
        if (!enable_i) begin
          w_nxt = S_IDLE;
        end else if (r_wait == WW'(SETTLE_CYC - 1)) begin
          w_nxt = S_START;
        end
      end
      S_START: begin
        // a falling finish flag beats a coincident timeout
        if (!adc_finish_i) begin
          w_nxt = S_CONVERT;
        end else if (r_wait == WW'(START_TO_CYC - 1)) begin
          w_to  = 1'b1;
          w_nxt = S_IDLE;
        end
      end
      S_CONVERT: begin
        if (adc_finish_i) w_nxt = S_STORE;
      end
      S_STORE: begin
        w_store = 1'b1;
        if (r_abort || !enable_i) begin
          w_nxt = S_IDLE;
        end else if (w_next[3]) begin
          w_nxt     = S_SELECT;
          w_sel_ld  = 1'b1;
          w_sel_val = w_next[2:0];
        end else begin
          w_done = 1'b1;
          w_nxt  = S_IDLE;
        end
      end
      default: w_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge nReset_i) begin
    if (!nReset_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_nxt;
    end
  end

  always_ff @(posedge clk_i or negedge nReset_i) begin
    if (!nReset_i) begin
      r_per_cnt <= '0;
    end else if (!enable_i || w_tick) begin
      r_per_cnt <= '0;
    end else begin
      r_per_cnt <= r_per_cnt + PW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge nReset_i) begin
    if (!nReset_i) begin
      r_wait <= '0;
    end else if (w_nxt != r_state) begin
      r_wait <= '0;
    end else if (r_state == S_SELECT ||
                 r_state == S_START) begin
      r_wait <= r_wait + WW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge nReset_i) begin
    if (!nReset_i) begin
      r_ch    <= '0;
      r_mask  <= '0;
      r_abort <= 1'b0;
      r_ovr   <= 1'b0;
      r_to    <= 1'b0;
    end else begin
      if (w_sel_ld) r_ch <= w_sel_val;
      if (r_state == S_IDLE && w_tick) r_mask <= ch_mask_i;
      // remembers an enable drop until the pending store is done
      if (r_state == S_IDLE) begin
        r_abort <= 1'b0;
      end else if (!enable_i) begin
        r_abort <= 1'b1;
      end
      if (w_tick && r_state != S_IDLE) r_ovr <= 1'b1;
      if (w_to) r_to <= 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge nReset_i) begin
    if (!nReset_i) begin
      r_valid <= '0;
      for (int k = 0; k < N_CH; k++) r_data[k] <= '0;
    end else if (w_store) begin
      for (int k = 0; k < N_CH; k++) begin
        if (r_ch == 3'(k)) begin
          r_data[k]  <= adc_data_i;
          r_valid[k] <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    ch_data_o = '0;
    for (int k = 0; k < N_CH; k++) begin
      ch_data_o[k*RES +: RES] = r_data[k];
    end
  end

  assign adc_enable_o = (r_state == S_START) ||
                        (r_state == S_CONVERT);
  assign mux_sel_o    = r_ch;
  assign ch_valid_o   = r_valid;
  assign scan_done_o  = w_done;
  assign busy_o       = (r_state != S_IDLE);
  assign overrun_o    = r_ovr;
  assign timeout_o    = r_to;

endmodule

// File: tb/tb_adc_scan_scheduler.sv
// Randomized bench for adc_scan_scheduler with a behavioural
// MCP3201 reader and a per-channel result model.
module tb_adc_scan_scheduler;

  localparam int N      = 4;
  localparam int RES    = 12;
  localparam int SETTLE = 5;
  localparam int PERIOD = 100;
  localparam int TO     = 64;

  logic             clk   = 1'b0;
  logic             rst_n = 1'b0;
  logic             en    = 1'b0;
  logic [N-1:0]     mask  = '0;
  logic             fin   = 1'b1;
  logic [RES-1:0]   dat   = '0;
  logic             adc_en;
  logic [2:0]       mux_sel;
  logic [N*RES-1:0] ch_data;
  logic [N-1:0]     ch_valid;
  logic             scan_done;
  logic             busy;
  logic             overrun;
  logic             timeout;

  adc_scan_scheduler #(
    .N_CH(N), .RES(RES), .SETTLE_CYC(SETTLE),
    .PERIOD_CYC(PERIOD), .START_TO_CYC(TO)
  ) dut (
    .clk_i(clk), .nReset_i(rst_n), .enable_i(en),
    .ch_mask_i(mask), .adc_finish_i(fin), .adc_data_i(dat),
    .adc_enable_o(adc_en), .mux_sel_o(mux_sel),
    .ch_data_o(ch_data), .ch_valid_o(ch_valid),
    .scan_done_o(scan_done), .busy_o(busy),
    .overrun_o(overrun), .timeout_o(timeout)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // reader model state and result model
  int             rd_lo    = 4;
  int             rd_hi    = 10;
  bit             rd_stuck = 1'b0;
  int             rst_gen  = 0;
  logic [2:0]     conv_hist [512];
  int             conv_n   = 0;
  logic [RES-1:0] exp_data [N];
  logic [N-1:0]   exp_valid;

  initial begin : reader
    int seen, g, lat, frm;
    logic [2:0]     ch;
    logic [RES-1:0] v;
    seen = 0;
    exp_valid = '0;
    for (int k = 0; k < N; k++) exp_data[k] = '0;
    forever begin
      @(posedge clk); #1;
      if (rst_gen != seen) begin
        seen = rst_gen;
        exp_valid = '0;
        for (int k = 0; k < N; k++) exp_data[k] = '0;
      end
      if (adc_en && !rd_stuck) begin
        g   = rst_gen;
        ch  = mux_sel;
        v   = RES'($urandom);
        lat = $urandom_range(0, 2);
        frm = $urandom_range(rd_lo, rd_hi);
        repeat (lat) begin @(posedge clk); #1; end
        fin = 1'b0;
        repeat (frm) begin @(posedge clk); #1; end
        dat = v;
        fin = 1'b1;
        if (g == rst_gen) begin
          conv_hist[conv_n] = ch;
          conv_n++;
          exp_data[int'(ch)]  = v;
          exp_valid[int'(ch)] = 1'b1;
        end
        for (int i = 0; i < 8 && adc_en; i++) begin
          @(posedge clk); #1;
        end
      end
    end
  end

  int   done_n = 0;
  int   rise_n = 0;
  logic en_q   = 1'b0;

  always @(negedge clk) begin
    done_n <= done_n + int'(scan_done);
    rise_n <= rise_n + int'(adc_en && !en_q);
    en_q   <= adc_en;
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    rst_gen++;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic check_model(input string tag);
    for (int k = 0; k < N; k++) begin
      chk($sformatf("%s_data%0d", tag, k),
          64'(ch_data[k*RES +: RES]), 64'(exp_data[k]));
    end
    chk({tag, "_valid"}, 64'(ch_valid), 64'(exp_valid));
  endtask

  // expected visit order: ascending set bits, once per scan
  task automatic check_order(input string tag, input int base,
                             input logic [N-1:0] m, input int reps);
    int e[$];
    for (int r = 0; r < reps; r++) begin
      for (int k = 0; k < N; k++) if (m[k]) e.push_back(k);
    end
    chk({tag, "_nconv"}, 64'(conv_n - base), 64'(e.size()));
    for (int i = 0; i < e.size() && base + i < conv_n; i++) begin
      chk($sformatf("%s_ch%0d", tag, i),
          64'(conv_hist[base + i]), 64'(e[i]));
    end
  endtask

  function automatic logic [63:0] all_out();
    return 64'({adc_en, mux_sel, ch_data, ch_valid,
                scan_done, busy, overrun, timeout});
  endfunction

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int base, d0, r0, hi;
    bit seen_en;

    #1;
    chk("reset_outputs", all_out(), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cycles(3);

    // full mask, three periods
    mask = 4'b1111;
    base = conv_n;
    d0   = done_n;
    en   = 1'b1;
    cycles(3 * PERIOD + 95);
    en = 1'b0;
    cycles(5);
    chk("t1_done", 64'(done_n - d0), 64'd3);
    chk("t1_overrun", 64'(overrun), 64'd0);
    chk("t1_busy", 64'(busy), 64'd0);
    check_order("t1", base, 4'b1111, 3);
    check_model("t1");
    chk("t1_valid_all", 64'(ch_valid), 64'hF);

    // sparse mask, then empty mask
    do_reset();
    cycles(2);
    mask = 4'b1010;
    base = conv_n;
    d0   = done_n;
    en   = 1'b1;
    cycles(PERIOD + 95);
    en = 1'b0;
    cycles(5);
    chk("t2_done", 64'(done_n - d0), 64'd1);
    check_order("t2", base, 4'b1010, 1);
    chk("t2_valid", 64'(ch_valid), 64'b1010);
    check_model("t2");
    mask = 4'b0000;
    d0   = done_n;
    r0   = rise_n;
    en   = 1'b1;
    cycles(PERIOD + 20);
    chk("t2_m0_busy", 64'(busy), 64'd0);
    en = 1'b0;
    cycles(3);
    chk("t2_m0_enable", 64'(rise_n - r0), 64'd0);
    chk("t2_m0_done", 64'(done_n - d0), 64'd0);

    // scans longer than the period
    chk("t3_overrun_pre", 64'(overrun), 64'd0);
    rd_lo = 30;
    rd_hi = 30;
    mask  = 4'b1111;
    base  = conv_n;
    d0    = done_n;
    en    = 1'b1;
    for (int i = 0; i < 800 && done_n - d0 < 2; i++) begin
      @(negedge clk); #1;
    end
    en = 1'b0;
    chk("t3_done_in_time", 64'(done_n - d0), 64'd2);
    cycles(5);
    chk("t3_overrun", 64'(overrun), 64'd1);
    check_order("t3", base, 4'b1111, 2);
    check_model("t3");
    rd_lo = 4;
    rd_hi = 10;

    // reader never leaves idle
    rd_stuck = 1'b1;
    mask     = 4'b0001;
    base     = conv_n;
    d0       = done_n;
    en       = 1'b1;
    seen_en  = 1'b0;
    for (int i = 0; i < 300 && !seen_en; i++) begin
      @(negedge clk);
      seen_en = adc_en;
    end
    chk("t4_enable_seen", 64'(seen_en), 64'd1);
    hi = 0;
    while (adc_en && hi < 200) begin
      hi++;
      @(negedge clk);
    end
    en = 1'b0;
    chk("t4_enable_cycles", 64'(hi), 64'(TO));
    chk("t4_timeout", 64'(timeout), 64'd1);
    chk("t4_adc_en", 64'(adc_en), 64'd0);
    chk("t4_busy", 64'(busy), 64'd0);
    chk("t4_noconv", 64'(conv_n - base), 64'd0);
    chk("t4_done", 64'(done_n - d0), 64'd0);
    rd_stuck = 1'b0;
    cycles(5);

    // enable dropped while channel 1 converts
    do_reset();
    #1;
    chk("t5_flags_cleared", 64'({overrun, timeout}), 64'd0);
    rd_lo   = 20;
    rd_hi   = 20;
    mask    = 4'b1111;
    base    = conv_n;
    d0      = done_n;
    en      = 1'b1;
    seen_en = 1'b0;
    for (int i = 0; i < 400 && !seen_en; i++) begin
      @(negedge clk);
      seen_en = adc_en && mux_sel == 3'd1 && !fin;
    end
    chk("t5_reach_ch1", 64'(seen_en), 64'd1);
    en = 1'b0;
    cycles(100);
    chk("t5_valid", 64'(ch_valid), 64'b0011);
    chk("t5_done", 64'(done_n - d0), 64'd0);
    chk("t5_busy", 64'(busy), 64'd0);
    check_order("t5", base, 4'b0011, 1);
    check_model("t5");
    rd_lo = 4;
    rd_hi = 10;

    // asynchronous reset during a conversion
    mask    = 4'b1111;
    en      = 1'b1;
    seen_en = 1'b0;
    for (int i = 0; i < 400 && !seen_en; i++) begin
      @(negedge clk);
      seen_en = adc_en && !fin && ch_valid != '0;
    end
    chk("t6_reach_conv", 64'(seen_en), 64'd1);
    #2;
    rst_n = 1'b0;
    rst_gen++;
    #1;
    chk("t6_async_zero", all_out(), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    base = conv_n;
    d0   = done_n;
    cycles(PERIOD + 95);
    en = 1'b0;
    cycles(5);
    chk("t6_done", 64'(done_n - d0), 64'd1);
    check_order("t6", base, 4'b1111, 1);
    check_model("t6");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
